// File: rtl/decode_stage_pkg.sv
// Shared decode constants: opcode encodings, instruction field positions,
// immediate-type classification and opcode helpers.
package decode_stage_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_LOAD   = 8'h03;
  localparam logic [7:0] OP_IMM    = 8'h13;
  localparam logic [7:0] OP_AUIPC  = 8'h17;
  localparam logic [7:0] OP_STORE  = 8'h23;
  localparam logic [7:0] OP_OP     = 8'h33;
  localparam logic [7:0] OP_LUI    = 8'h37;
  localparam logic [7:0] OP_BRANCH = 8'h63;
  localparam logic [7:0] OP_JALR   = 8'h67;
  localparam logic [7:0] OP_JAL    = 8'h6F;

  localparam logic [63:0] INSTR_NOP = 64'h0;

  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned RD_LSB     = 8;
  localparam int unsigned FUNCT3_LSB = 13;
  localparam int unsigned RS1_LSB    = 16;
  localparam int unsigned RS2_LSB    = 21;
  localparam int unsigned IMM_LSB    = 32;

  typedef enum logic [1:0] {
    IMM_NONE,
    IMM_I,
    IMM_B,
    IMM_U
  } imm_type_e;

  function automatic imm_type_e imm_type(input logic [7:0] op);
    case (op)
      OP_IMM, OP_LOAD, OP_JALR, OP_STORE: return IMM_I;
      OP_BRANCH, OP_JAL:                  return IMM_B;
      OP_LUI, OP_AUIPC:                   return IMM_U;
      default:                            return IMM_NONE;
    endcase
  endfunction

  function automatic logic is_known_opcode(input logic [7:0] op);
    case (op)
      OP_NOP, OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE,
      OP_OP, OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: instruction word in, sign-extended /
// shifted immediate out, selected by opcode.
module decode_imm_gen
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] i_instr,
  output logic [XLEN-1:0] o_imm
);

  logic [31:0]     w_src;
  logic [XLEN-1:0] w_sext;
  logic            w_unused;

  assign w_src    = i_instr[IMM_LSB +: 32];
  assign w_sext   = {{(XLEN-32){w_src[31]}}, w_src};
  assign w_unused = ^i_instr[IMM_LSB-1:8];

  always_comb begin
    o_imm = '0;
    case (imm_type(i_instr[OPCODE_LSB +: 8]))
      IMM_I:   o_imm = w_sext;
      IMM_B:   o_imm = w_sext << 1;
      IMM_U:   o_imm = {w_src, {(XLEN-32){1'b0}}};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field split, register-file addressing, load-use hazard bubble.
// Optional illegal-opcode trap enabled by `define DECODE_ILLEGAL_TRAP_EN.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_in,
  input  logic                 flush_in,
  input  logic [XLEN-1:0]      pc_in,
  input  logic [63:0]          instr_in,
  input  logic                 branch_predicted_taken_in,
  output logic                 stall_out,
  output logic [REG_IDX_W-1:0] rf_rs1_addr_out,
  output logic [REG_IDX_W-1:0] rf_rs2_addr_out,
  output logic                 valid_out,
  output logic [XLEN-1:0]      pc_out,
  output logic [7:0]           opcode_out,
  output logic [REG_IDX_W-1:0] rd_out,
  output logic [REG_IDX_W-1:0] rs1_out,
  output logic [REG_IDX_W-1:0] rs2_out,
  output logic [2:0]           funct3_out,
  output logic [XLEN-1:0]      imm_out,
  output logic                 is_load_out,
  output logic                 branch_predicted_taken_out,
  output logic                 illegal_out
);

  logic [7:0]           w_opcode;
  logic [REG_IDX_W-1:0] w_rd, w_rs1, w_rs2, w_rd_wb;
  logic [2:0]           w_funct3;
  logic [XLEN-1:0]      w_imm;
  logic                 w_uses_rs1, w_uses_rs2, w_hazard, w_illegal;
  logic                 w_unused;

  logic                 r_valid, r_is_load, r_pred, r_illegal;
  logic [XLEN-1:0]      r_pc, r_imm;
  logic [7:0]           r_opcode;
  logic [REG_IDX_W-1:0] r_rd, r_rs1, r_rs2;
  logic [2:0]           r_funct3;

  assign w_opcode = instr_in[OPCODE_LSB +: 8];
  assign w_rd     = instr_in[RD_LSB +: REG_IDX_W];
  assign w_funct3 = instr_in[FUNCT3_LSB +: 3];
  assign w_rs1    = instr_in[RS1_LSB +: REG_IDX_W];
  assign w_rs2    = instr_in[RS2_LSB +: REG_IDX_W];
  assign w_unused = ^instr_in[IMM_LSB-1:RS2_LSB+REG_IDX_W];

  decode_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr (instr_in),
    .o_imm   (w_imm)
  );

  assign w_uses_rs1 = !(w_opcode == OP_LUI || w_opcode == OP_AUIPC || w_opcode == OP_JAL);
  assign w_uses_rs2 = (w_opcode == OP_OP || w_opcode == OP_STORE || w_opcode == OP_BRANCH);

  // Compare against what was last issued; a flushed instruction never stalls.
  assign w_hazard = r_valid && r_is_load && (r_rd != '0) && !flush_in &&
                    ((w_uses_rs1 && (w_rs1 == r_rd)) || (w_uses_rs2 && (w_rs2 == r_rd)));

  assign stall_out       = stall_in | w_hazard;
  assign rf_rs1_addr_out = w_rs1;
  assign rf_rs2_addr_out = w_rs2;

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign w_illegal = !is_known_opcode(w_opcode);
`else
  assign w_illegal = 1'b0;
`endif
  assign w_rd_wb = w_illegal ? '0 : w_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_opcode  <= INSTR_NOP[7:0];
      r_rd      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_funct3  <= '0;
      r_imm     <= '0;
      r_is_load <= 1'b0;
      r_pred    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (!stall_in) begin
      if (flush_in || w_hazard) begin
        r_valid   <= 1'b0;
        r_pc      <= '0;
        r_opcode  <= OP_NOP;
        r_rd      <= '0;
        r_rs1     <= '0;
        r_rs2     <= '0;
        r_funct3  <= '0;
        r_imm     <= '0;
        r_is_load <= 1'b0;
        r_pred    <= 1'b0;
        r_illegal <= 1'b0;
      end else begin
        r_valid   <= (instr_in != INSTR_NOP);
        r_pc      <= pc_in;
        r_opcode  <= w_opcode;
        r_rd      <= w_rd_wb;
        r_rs1     <= w_rs1;
        r_rs2     <= w_rs2;
        r_funct3  <= w_funct3;
        r_imm     <= w_imm;
        r_is_load <= (w_opcode == OP_LOAD);
        r_pred    <= branch_predicted_taken_in;
        r_illegal <= w_illegal;
      end
    end
  end

  assign valid_out                  = r_valid;
  assign pc_out                     = r_pc;
  assign opcode_out                 = r_opcode;
  assign rd_out                     = r_rd;
  assign rs1_out                    = r_rs1;
  assign rs2_out                    = r_rs2;
  assign funct3_out                 = r_funct3;
  assign imm_out                    = r_imm;
  assign is_load_out                = r_is_load;
  assign branch_predicted_taken_out = r_pred;
  assign illegal_out                = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with an expected-output scoreboard queue.
// Honours DECODE_ILLEGAL_TRAP_EN for the illegal-opcode expectations.
module tb_decode_stage;

  localparam logic [7:0] T_LOAD = 8'h03, T_IMM = 8'h13, T_AUIPC = 8'h17, T_STORE = 8'h23,
                         T_OP = 8'h33, T_LUI = 8'h37, T_BRANCH = 8'h63, T_JALR = 8'h67;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [7:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [63:0] imm;
    logic        ld, pred, ill;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0, stall_in = 1'b0, flush_in = 1'b0, pred_in = 1'b0;
  logic [63:0] pc_in = '0, instr_in = '0;
  logic        stall_out, valid_out, is_load_out, pred_out, illegal_out;
  logic [4:0]  rf_rs1, rf_rs2, rd_out, rs1_out, rs2_out;
  logic [63:0] pc_out, imm_out;
  logic [7:0]  opcode_out;
  logic [2:0]  funct3_out;

  int unsigned n_cmp = 0, n_mis = 0;
  exp_t        sb[$];
  exp_t        last, e, got;
  logic [63:0] w;

  decode_stage #(.XLEN(64), .REG_IDX_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush_in(flush_in),
    .pc_in(pc_in), .instr_in(instr_in), .branch_predicted_taken_in(pred_in),
    .stall_out(stall_out), .rf_rs1_addr_out(rf_rs1), .rf_rs2_addr_out(rf_rs2),
    .valid_out(valid_out), .pc_out(pc_out), .opcode_out(opcode_out), .rd_out(rd_out),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .funct3_out(funct3_out), .imm_out(imm_out),
    .is_load_out(is_load_out), .branch_predicted_taken_out(pred_out), .illegal_out(illegal_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] enc(input logic [7:0] op, input logic [4:0] rd,
      input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    return {imm, 6'b0, rs2, rs1, f3, rd, op};
  endfunction

  function automatic exp_t dec(input logic v, input logic [63:0] pc, input logic [63:0] ins,
      input logic [63:0] imm, input logic pred);
    exp_t x;
    x.valid = v;     x.pc = pc;          x.op = ins[7:0];
    x.rd = ins[12:8]; x.f3 = ins[15:13]; x.rs1 = ins[20:16]; x.rs2 = ins[25:21];
    x.imm = imm;     x.ld = (ins[7:0] == T_LOAD);
    x.pred = pred;   x.ill = 1'b0;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input exp_t x);
    chk({tag, ".valid"}, {63'b0, valid_out}, {63'b0, x.valid});
    chk({tag, ".pc"}, pc_out, x.pc);
    chk({tag, ".opcode"}, {56'b0, opcode_out}, {56'b0, x.op});
    chk({tag, ".rd"}, {59'b0, rd_out}, {59'b0, x.rd});
    chk({tag, ".rs1"}, {59'b0, rs1_out}, {59'b0, x.rs1});
    chk({tag, ".rs2"}, {59'b0, rs2_out}, {59'b0, x.rs2});
    chk({tag, ".funct3"}, {61'b0, funct3_out}, {61'b0, x.f3});
    chk({tag, ".imm"}, imm_out, x.imm);
    chk({tag, ".is_load"}, {63'b0, is_load_out}, {63'b0, x.ld});
    chk({tag, ".pred"}, {63'b0, pred_out}, {63'b0, x.pred});
    chk({tag, ".illegal"}, {63'b0, illegal_out}, {63'b0, x.ill});
  endtask

  // Drive one cycle of inputs, check combinational outputs, queue the expected
  // register contents, then pop and compare after the capturing edge.
  task automatic step(input string tag, input logic [63:0] ins, input logic [63:0] pc,
      input logic pred, input logic st, input logic fl, input logic exp_stall, input exp_t x);
    @(negedge clk);
    instr_in = ins; pc_in = pc; pred_in = pred; stall_in = st; flush_in = fl;
    #1;
    chk({tag, ".stall_out"}, {63'b0, stall_out}, {63'b0, exp_stall});
    chk({tag, ".rf_rs1"}, {59'b0, rf_rs1}, {59'b0, ins[20:16]});
    chk({tag, ".rf_rs2"}, {59'b0, rf_rs2}, {59'b0, ins[25:21]});
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_mis++;
      $display("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end else begin
      got = sb.pop_front();
      chk_regs(tag, got);
    end
    last = x;
  endtask

  initial begin
    // Reset with random instructions and stall_in toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      instr_in = {$urandom, $urandom}; pc_in = {$urandom, $urandom};
      stall_in = i[0]; pred_in = 1'b1;
      #1;
      chk_regs("reset", '0);
      chk("reset.stall_out", {63'b0, stall_out}, {63'b0, stall_in});
    end
    @(negedge clk);
    rst_n = 1'b1; stall_in = 1'b0; pred_in = 1'b0;

    w = enc(T_IMM, 5'd3, 3'd0, 5'd1, 5'd0, 32'hFFFF_FFF0);
    step("addi", w, 64'h100, 1'b0, 1'b0, 1'b0, 1'b0, dec(1'b1, 64'h100, w, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0));
    w = enc(T_LOAD, 5'd5, 3'd3, 5'd2, 5'd0, 32'h8);
    step("load5", w, 64'h104, 1'b1, 1'b0, 1'b0, 1'b0, dec(1'b1, 64'h104, w, 64'h8, 1'b1));
    w = enc(T_OP, 5'd6, 3'd0, 5'd7, 5'd5, 32'h1234);
    step("op_hazard", w, 64'h108, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    step("op_issue", w, 64'h108, 1'b0, 1'b0, 1'b0, 1'b0, dec(1'b1, 64'h108, w, 64'h0, 1'b0));
    w = enc(T_LOAD, 5'd0, 3'd2, 5'd1, 5'd0, 32'h4);
    step("load0", w, 64'h10C, 1'b0, 1'b0, 1'b0, 1'b0, dec(1'b1, 64'h10C, w, 64'h4, 1'b0));
    w = enc(T_OP, 5'd7, 3'd0, 5'd0, 5'd0, 32'h0);
    step("op_after_x0", w, 64'h110, 1'b0, 1'b0, 1'b0, 1'b0, dec(1'b1, 64'h110, w, 64'h0, 1'b0));
    w = enc(T_LOAD, 5'd9, 3'd3, 5'd3, 5'd0, 32'hFFFF_FFFC);
    step("load9", w, 64'h114, 1'b0, 1'b0, 1'b0, 1'b0, dec(1'b1, 64'h114, w, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0));
    w = enc(T_JALR, 5'd1, 3'd0, 5'd9, 5'd0, 32'h10);
    step("flush", w, 64'h118, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    w = enc(T_LOAD, 5'd4, 3'd3, 5'd1, 5'd0, 32'h40);
    step("load4", w, 64'h11C, 1'b0, 1'b0, 1'b0, 1'b0, dec(1'b1, 64'h11C, w, 64'h40, 1'b0));
    w = enc(T_LUI, 5'd8, 3'd0, 5'd4, 5'd0, 32'h0001_2345);
    step("lui", w, 64'h120, 1'b0, 1'b0, 1'b0, 1'b0, dec(1'b1, 64'h120, w, 64'h0001_2345_0000_0000, 1'b0));
    w = enc(T_BRANCH, 5'd0, 3'd1, 5'd2, 5'd3, 32'hFFFF_FFFE);
    step("branch", w, 64'h124, 1'b1, 1'b0, 1'b0, 1'b0, dec(1'b1, 64'h124, w, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1));
    w = 64'h0;
    step("nop", w, 64'h200, 1'b0, 1'b0, 1'b0, 1'b0, dec(1'b0, 64'h200, w, 64'h0, 1'b0));
    w = enc(T_LOAD, 5'd10, 3'd3, 5'd1, 5'd0, 32'h0);
    step("load10", w, 64'h12C, 1'b0, 1'b0, 1'b0, 1'b0, dec(1'b1, 64'h12C, w, 64'h0, 1'b0));

    // Downstream stall with a flush pulse in the middle, then the hazard.
    w = enc(T_STORE, 5'd0, 3'd3, 5'd10, 5'd11, 32'h20);
    step("stall1", w, 64'h130, 1'b0, 1'b1, 1'b0, 1'b1, last);
    step("stall2_flush", w, 64'h130, 1'b0, 1'b1, 1'b1, 1'b1, last);
    step("stall3", w, 64'h130, 1'b0, 1'b1, 1'b0, 1'b1, last);
    step("store_hazard", w, 64'h130, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    step("store_issue", w, 64'h130, 1'b0, 1'b0, 1'b0, 1'b0, dec(1'b1, 64'h130, w, 64'h20, 1'b0));

    w = enc(8'hFF, 5'd12, 3'd0, 5'd0, 5'd0, 32'h55);
    e = dec(1'b1, 64'h134, w, 64'h0, 1'b0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    e.rd = 5'd0; e.ill = 1'b1;
`endif
    step("illegal", w, 64'h134, 1'b0, 1'b0, 1'b0, 1'b0, e);
    w = enc(T_AUIPC, 5'd13, 3'd0, 5'd0, 5'd0, 32'h1);
    step("auipc", w, 64'h138, 1'b0, 1'b0, 1'b0, 1'b0, dec(1'b1, 64'h138, w, 64'h1_0000_0000, 1'b0));

    // Asynchronous reset asserted while stalled.
    @(negedge clk);
    stall_in = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_regs("midreset", '0);
    chk("midreset.stall_out", {63'b0, stall_out}, 64'd1);
    stall_in = 1'b0;
    #1;
    chk("midreset.stall_drop", {63'b0, stall_out}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
